// File: rtl/instr_encoder.sv
// Instruction encoder: checks an intended immediate against the opcode's extension
// rule, packs the instruction word and writes it to instruction memory through an acked port.
module instr_encoder #(
   parameter int          ADDR_W    = 10,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              addr_load,
   input  logic [ADDR_W-1:0] addr_init,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        opcode,
   input  logic [4:0]        rs,
   input  logic [4:0]        rd,
   input  logic [4:0]        rt,
   input  logic [5:0]        func,
   input  logic [31:0]       immed_val,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [15:0]       instr_count,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ENCODE, WRITE} state_t;

   localparam logic [1:0] CODE_OK     = 2'b00;
   localparam logic [1:0] CODE_ILLEGAL = 2'b01;
   localparam logic [1:0] CODE_RANGE  = 2'b10;
   localparam logic [1:0] CODE_ALIGN  = 2'b11;

   // Returns {error code, 16-bit field}; the rules invert the CPU's immediate extension.
   function automatic logic [17:0] encode(input logic [5:0] op, input logic [4:0] rt_f,
                                          input logic [5:0] fn, input logic [31:0] imm);
      logic [1:0]  code;
      logic [15:0] field;
      code  = CODE_OK;
      field = imm[15:0];
      case (op)
         6'b110000, 6'b111000, 6'b000011, 6'b000111, 6'b001111, 6'b011111: begin
            if (!((&imm[31:15]) || !(|imm[31:15]))) code = CODE_RANGE;
         end
         6'b111001: begin
            if (|imm[15:0]) code = CODE_RANGE;
            field = imm[31:16];
         end
         6'b110010, 6'b110011: begin
            if (|imm[31:16]) code = CODE_RANGE;
         end
         6'b111111, 6'b000000, 6'b000001: begin
            if (|imm[1:0])        code = CODE_ALIGN;
            else if (|imm[31:18]) code = CODE_RANGE;
            field = imm[17:2];
         end
         6'b100000: field = {rt_f, 5'b0, fn};
         default: begin
            code  = CODE_ILLEGAL;
            field = '0;
         end
      endcase
      return {code, field};
   endfunction

   state_t            state_q, state_d;
   logic [5:0]        op_q, op_d, func_q, func_d;
   logic [4:0]        rs_q, rs_d, rd_q, rd_d, rt_q, rt_d;
   logic [31:0]       imm_q, imm_d;
   logic              we_q, we_d, err_q, err_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [1:0]        code_q, code_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [17:0]       enc_res;

   assign enc_res     = encode(op_q, rt_q, func_q, imm_q);
   assign in_ready    = (state_q == IDLE) && !addr_load;
   assign busy        = (state_q != IDLE);
   assign mem_we      = we_q;
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign err         = err_q;
   assign err_code    = code_q;
   assign instr_count = cnt_q;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      rs_d    = rs_q;
      rd_d    = rd_q;
      rt_d    = rt_q;
      func_d  = func_q;
      imm_d   = imm_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = 1'b0;
      code_d  = code_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (addr_load) begin
               addr_d = addr_init;
            end else if (in_valid) begin
               op_d    = opcode;
               rs_d    = rs;
               rd_d    = rd;
               rt_d    = rt;
               func_d  = func;
               imm_d   = immed_val;
               state_d = ENCODE;
            end
         end
         ENCODE: begin
            if (enc_res[17:16] == CODE_OK) begin
               wdata_d = {op_q, rs_q, rd_q, enc_res[15:0]};
               we_d    = 1'b1;
               state_d = WRITE;
            end else begin
               err_d   = 1'b1;
               code_d  = enc_res[17:16];
               state_d = IDLE;
            end
         end
         WRITE: begin
            // Strobe, address and data stay frozen until memory acknowledges.
            if (mem_ack) begin
               we_d    = 1'b0;
               addr_d  = addr_q + 1'b1;
               if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
               code_d  = CODE_OK;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         rs_q    <= '0;
         rd_q    <= '0;
         rt_q    <= '0;
         func_q  <= '0;
         imm_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= ADDR_W'(BASE_ADDR);
         wdata_q <= '0;
         err_q   <= 1'b0;
         code_q  <= CODE_OK;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rs_q    <= rs_d;
         rd_q    <= rd_d;
         rt_q    <= rt_d;
         func_q  <= func_d;
         imm_q   <= imm_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         code_q  <= code_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus queues expected writes/errors,
// a monitor pops them whenever the DUT strobes a write or pulses err.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        addr_load = 1'b0;
   logic [9:0]  addr_init = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [5:0]  opcode = '0;
   logic [4:0]  rs = '0, rd = '0, rt = '0;
   logic [5:0]  func = '0;
   logic [31:0] immed_val = '0;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic        err;
   logic [1:0]  err_code;
   logic [15:0] instr_count;
   logic        busy;

   instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
      .clk(clk), .rst_n(rst_n), .addr_load(addr_load), .addr_init(addr_init),
      .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .rs(rs), .rd(rd),
      .rt(rt), .func(func), .immed_val(immed_val), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .err(err), .err_code(err_code),
      .instr_count(instr_count), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_err;
      logic [1:0]  code;
      logic [9:0]  addr;
      logic [31:0] data;
   } exp_t;

   exp_t expq[$];
   int   total = 0;
   int   passed = 0;
   int   ack_delay = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic push_wr(input logic [9:0] a, input logic [31:0] d);
      exp_t e;
      e.is_err = 1'b0; e.code = 2'b00; e.addr = a; e.data = d;
      expq.push_back(e);
   endtask

   task automatic push_err(input logic [1:0] c);
      exp_t e;
      e.is_err = 1'b1; e.code = c; e.addr = '0; e.data = '0;
      expq.push_back(e);
   endtask

   // Returns just after the accepting edge (#1 later).
   task automatic accept(input logic [5:0] op, input logic [4:0] s, input logic [4:0] d,
                         input logic [4:0] t, input logic [5:0] f, input logic [31:0] imm);
      int n;
      @(negedge clk);
      opcode = op; rs = s; rd = d; rt = t; func = f; immed_val = imm;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while ((busy || mem_we) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy || mem_we) chk("idle_timeout", 32'd0, 32'd1);
   endtask

   // Memory responder: acknowledges ack_delay cycles after the strobe appears.
   initial begin
      forever begin
         @(negedge clk);
         if (mem_we && rst_n) begin
            repeat (ack_delay) @(negedge clk);
            mem_ack = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
         end
      end
   end

   // Monitor / scoreboard.
   initial begin
      logic        prev_we;
      logic [9:0]  cur_addr;
      logic [31:0] cur_data;
      exp_t        e;
      prev_we = 1'b0; cur_addr = '0; cur_data = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_we = 1'b0;
         end else begin
            if (mem_we && !prev_we) begin
               if (expq.size() == 0) chk("unexpected_write", {22'd0, mem_addr}, 32'hFFFFFFFF);
               else begin
                  e = expq.pop_front();
                  chk("wr_is_write", {31'd0, e.is_err}, 32'd0);
                  chk("wr_addr", {22'd0, mem_addr}, {22'd0, e.addr});
                  chk("wr_data", mem_wdata, e.data);
                  cur_addr = mem_addr;
                  cur_data = mem_wdata;
               end
            end else if (mem_we && prev_we) begin
               chk("hold_addr", {22'd0, mem_addr}, {22'd0, cur_addr});
               chk("hold_data", mem_wdata, cur_data);
            end
            if (err) begin
               if (expq.size() == 0) chk("unexpected_err", {30'd0, err_code}, 32'hFFFFFFFF);
               else begin
                  e = expq.pop_front();
                  chk("err_is_err", {31'd0, e.is_err}, 32'd1);
                  chk("err_code", {30'd0, err_code}, {30'd0, e.code});
                  chk("err_no_we", {31'd0, mem_we}, 32'd0);
               end
            end
            prev_we = mem_we;
         end
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_err_code", {30'd0, err_code}, 32'd0);
      chk("rst_count", {16'd0, instr_count}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;

      // Sign class, with latency check
      push_wr(10'h000, 32'hC045FFFC);
      accept(6'b110000, 5'd2, 5'd5, 5'd0, 6'd0, 32'hFFFFFFFC);
      chk("lat_we_n1", {31'd0, mem_we}, 32'd0);
      chk("lat_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      chk("lat_we_n2", {31'd0, mem_we}, 32'd1);
      wait_idle();
      chk("sign_count", {16'd0, instr_count}, 32'd1);
      chk("sign_addr_inc", {22'd0, mem_addr}, 32'd1);

      // Upper class: pass then fail
      push_wr(10'h001, 32'hE4011234);
      accept(6'b111001, 5'd0, 5'd1, 5'd0, 6'd0, 32'h12340000);
      wait_idle();
      push_err(2'b10);
      accept(6'b111001, 5'd0, 5'd1, 5'd0, 6'd0, 32'h12340001);
      wait_idle();
      chk("upper_err_addr", {22'd0, mem_addr}, 32'd2);
      chk("upper_err_count", {16'd0, instr_count}, 32'd2);
      chk("upper_err_code_held", {30'd0, err_code}, 32'd2);

      // Branch class, range and illegal cases
      push_wr(10'h002, 32'h00220004);
      accept(6'b000000, 5'd1, 5'd2, 5'd0, 6'd0, 32'h00000010);
      wait_idle();
      chk("branch_err_code_clr", {30'd0, err_code}, 32'd0);
      push_err(2'b11);
      accept(6'b000000, 5'd1, 5'd2, 5'd0, 6'd0, 32'h00000012);
      wait_idle();
      push_err(2'b10);
      accept(6'b110011, 5'd1, 5'd2, 5'd0, 6'd0, 32'h00010000);
      wait_idle();
      push_err(2'b10);
      accept(6'b110000, 5'd1, 5'd2, 5'd0, 6'd0, 32'h00008000);
      wait_idle();
      push_err(2'b01);
      accept(6'b101010, 5'd1, 5'd2, 5'd0, 6'd0, 32'h00000000);
      wait_idle();
      chk("errs_addr", {22'd0, mem_addr}, 32'd3);
      chk("errs_count", {16'd0, instr_count}, 32'd3);

      // R-type with delayed ack
      ack_delay = 3;
      push_wr(10'h003, 32'h80642830);
      accept(6'b100000, 5'd3, 5'd4, 5'd5, 6'h30, 32'hDEADBEEF);
      begin
         int n;
         n = 0;
         while (!mem_we && n < 20) begin @(negedge clk); n++; end
      end
      for (int i = 0; i < 3; i++) begin
         chk("rtype_in_ready", {31'd0, in_ready}, 32'd0);
         chk("rtype_busy", {31'd0, busy}, 32'd1);
         chk("rtype_addr_wait", {22'd0, mem_addr}, 32'd3);
         @(negedge clk);
      end
      wait_idle();
      chk("rtype_addr_after", {22'd0, mem_addr}, 32'd4);
      chk("rtype_count", {16'd0, instr_count}, 32'd4);
      ack_delay = 0;

      // Address load and wrap
      @(negedge clk);
      addr_load = 1'b1; addr_init = 10'h3FF;
      #1 chk("load_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      addr_load = 1'b0;
      chk("load_addr", {22'd0, mem_addr}, 32'h3FF);
      push_wr(10'h3FF, 32'hC0000005);
      accept(6'b110000, 5'd0, 5'd0, 5'd0, 6'd0, 32'h00000005);
      wait_idle();
      push_wr(10'h000, 32'hC821ABCD);
      accept(6'b110010, 5'd1, 5'd1, 5'd0, 6'd0, 32'h0000ABCD);
      wait_idle();
      chk("wrap_addr", {22'd0, mem_addr}, 32'd1);
      chk("wrap_count", {16'd0, instr_count}, 32'd6);

      // Asynchronous reset during WRITE
      ack_delay = 20;
      push_wr(10'h001, 32'hC0000007);
      accept(6'b110000, 5'd0, 5'd0, 5'd0, 6'd0, 32'h00000007);
      begin
         int n;
         n = 0;
         while (!mem_we && n < 20) begin @(negedge clk); n++; end
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_we", {31'd0, mem_we}, 32'd0);
      chk("arst_addr", {22'd0, mem_addr}, 32'd0);
      chk("arst_count", {16'd0, instr_count}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("queue_drained", expq.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Program-load-side inverse of the datapath's immediate-extension stage. It accepts decoded instruction fields plus a full 32-bit intended immediate value, and checks that the value is representable by the opcode's extension rule. It then packs a 32-bit instruction word and writes it into instruction memory at an auto-incrementing address through an acknowledged write port. It is used by the bench and the boot loader to build program images that the CPU's immediate decoder reproduces exactly.

Parameters:
ADDR_W, 10, width of instruction-memory word address; address wraps modulo 2^ADDR_W.
BASE_ADDR, 0, address loaded on reset.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
addr_load  input  1  load write address from addr_init (honoured in IDLE only).
addr_init  input  ADDR_W  new write address.
in_valid  input  1  request valid.
in_ready  output  1  request accepted when in_valid && in_ready at clk edge.
opcode  input  6  instruction opcode.
rs  input  5  source register field.
rd  input  5  destination register field.
rt  input  5  second source register (R-type only).
func  input  6  function field (R-type only).
immed_val  input  32  intended post-extension immediate value.
mem_we  output  1  memory write strobe.
mem_addr  output  ADDR_W  write word address.
mem_wdata  output  32  encoded instruction word.
mem_ack  input  1  memory accepted the write this cycle.
err  output  1  one-cycle pulse: request rejected.
err_code  output  2  00 none, 01 illegal opcode, 10 immediate out of range, 11 misaligned branch offset; held until next request completes.
instr_count  output  16  instructions written since reset; saturates at 0xFFFF.
busy  output  1  state != IDLE.

Behaviour:
- Word layout: [31:26] opcode, [25:21] rs, [20:16] rd, [15:0] field.
- Sign class (opcodes 110000, 111000, 000011, 000111, 001111, 011111): immed_val[31:15] must be all equal, else code 10. Field = immed_val[15:0].
- Upper class (111001): immed_val[15:0] must be 0, else code 10. Field = immed_val[31:16].
- Zero class (110010, 110011): immed_val[31:16] must be 0, else code 10. Field = immed_val[15:0].
- Branch class (111111, 000000, 000001): immed_val[1:0] must be 0, else code 11. immed_val[31:18] must be 0, else code 10. Field = immed_val[17:2].
- R-type (100000): field = {rt, 5'b0, func}; immed_val ignored.
- Any other opcode: code 01.
- Check priority: 01 > 11 > 10.
- FSM states: IDLE, ENCODE, WRITE.
- IDLE: in_ready=1 unless addr_load=1. If addr_load=1, mem_addr<=addr_init and no request is accepted that cycle. On accept, all inputs are registered and the FSM moves to ENCODE.
- ENCODE (one cycle): encoding and checks are performed on the registered fields.
  - Pass: mem_wdata is registered, mem_we<=1, and the FSM moves to WRITE.
  - Fail: err<=1 for exactly one cycle, err_code is set, no write occurs, address and count are unchanged, and the FSM returns to IDLE.
- WRITE: mem_we, mem_addr and mem_wdata are held stable until mem_ack is sampled high. On that edge:
  - mem_we<=0;
  - mem_addr<=mem_addr+1 (0x3FF wraps to 0x000 at the default width);
  - instr_count increments (saturating);
  - err_code<=00;
  - FSM returns to IDLE.
- mem_ack outside WRITE is ignored. addr_load outside IDLE is ignored.
- Latency: accept at edge N; mem_we is high from cycle N+2. Minimum throughput is one instruction per 3 cycles (mem_ack high in the first WRITE cycle).
- Reset values: state IDLE, in_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, err=0, err_code=00, instr_count=0, busy=0.
- Asserting rst_n low mid-write drops mem_we immediately (asynchronously). No partial state survives the reset.

Test Plan:
- Sign class: opcode=110000, rs=2, rd=5, immed_val=0xFFFFFFFC -> mem_wdata=0xC045FFFC at mem_addr 0; instr_count=1; mem_we high 2 cycles after accept.
- Upper class: opcode=111001, rd=1, immed_val=0x12340000 -> mem_wdata=0xE4011234. Same opcode with 0x12340001 -> err pulse, err_code=10, no mem_we, address unchanged.
- Branch class: opcode=000000, rs=1, rd=2, immed_val=0x10 -> 0x00220004. immed_val=0x12 -> err_code=11. Range: opcode=110011 with 0x00010000, and opcode=110000 with 0x00008000 -> err_code=10 each. opcode=101010 -> err_code=01.
- R-type with delayed ack: opcode=100000, rs=3, rd=4, rt=5, func=0x30, mem_ack delayed 3 cycles -> mem_wdata=0x80642830. mem_we, mem_addr and mem_wdata stay stable all 3 cycles. in_ready=0 and busy=1 throughout; mem_addr increments only after mem_ack.
- Wrap and reset: addr_load with addr_init=0x3FF, then two valid writes -> addresses 0x3FF then 0x000. Then rst_n low during WRITE -> mem_we=0 immediately, mem_addr=0, instr_count=0, state IDLE.
